// File: rtl/vc_input_buffer.sv
// Multi-VC router input buffer: per-VC circular FIFOs with packet
// framing checks and a round-robin, stall-stable output stream.
module vc_input_buffer #(
  parameter int FLIT_W = 34,
  parameter int N_VC   = 2,
  parameter int DEPTH  = 4,
  localparam int VC_W  = (N_VC > 1) ? $clog2(N_VC) : 1,
  localparam int OCW   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [VC_W-1:0]       vc_id_i,
  input  logic [FLIT_W-1:0]     fdata_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [FLIT_W-1:0]     fdata_o,
  output logic [VC_W-1:0]       vc_id_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [N_VC*OCW-1:0]   ocup_o,
  output logic [N_VC-1:0]       err_o
);

  localparam int AW = OCW - 1;
  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] HT   = 2'b11;

  typedef enum logic {IDLE, PKT} fsm_e;

  logic [FLIT_W-1:0] mem_q [N_VC][DEPTH];
  logic [OCW-1:0]    wr_q [N_VC];
  logic [OCW-1:0]    wr_d [N_VC];
  logic [OCW-1:0]    rd_q [N_VC];
  logic [OCW-1:0]    rd_d [N_VC];
  fsm_e              st_q [N_VC];
  fsm_e              st_d [N_VC];

  logic [N_VC-1:0] err_q, err_d;
  logic [N_VC-1:0] empty, full, legal, store;
  logic [VC_W-1:0] rr_q, rr_d, hvc_q, hvc_d;
  logic [VC_W-1:0] scan, sel;
  logic            hold_q, hold_d;
  logic            found, wr_en, rd_en;
  logic [1:0]      ftyp;

  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      empty[v] = wr_q[v] == rd_q[v];
      full[v]  = (wr_q[v][AW-1:0] == rd_q[v][AW-1:0])
              && (wr_q[v][AW] != rd_q[v][AW]);
      ocup_o[v*OCW +: OCW] = wr_q[v] - rd_q[v];
    end
  end

  assign ready_o = !full[vc_id_i];
  assign wr_en   = valid_i && ready_o;
  assign ftyp    = fdata_i[FLIT_W-1 -: 2];
  assign err_o   = err_q;

  // Framing FSM output: is the incoming flit type legal in this state
  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      legal[v] = 1'b0;
      unique case (st_q[v])
        IDLE: legal[v] = (ftyp == HEAD) || (ftyp == HT);
        PKT:  legal[v] = (ftyp == BODY) || (ftyp == TAIL);
        default: legal[v] = 1'b0;
      endcase
    end
  end

  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      st_d[v]  = st_q[v];
      err_d[v] = err_q[v];
      store[v] = 1'b0;
      if (wr_en && vc_id_i == VC_W'(v)) begin
        if (!legal[v]) begin
          err_d[v] = 1'b1;
        end else begin
          store[v] = 1'b1;
          if (ftyp == HEAD) st_d[v] = PKT;
          if (ftyp == TAIL) st_d[v] = IDLE;
        end
      end
    end
  end

  always_comb begin
    scan  = rr_q;
    found = 1'b0;
    for (int k = 0; k < N_VC; k++) begin
      if (!found && !empty[(int'(rr_q) + k) % N_VC]) begin
        found = 1'b1;
        scan  = VC_W'((int'(rr_q) + k) % N_VC);
      end
    end
  end

  // A stalled flit pins the selection so fdata_o/vc_id_o stay put
  assign sel     = hold_q ? hvc_q : scan;
  assign valid_o = !empty[sel];
  assign vc_id_o = sel;
  assign rd_en   = valid_o && ready_i;
  assign fdata_o = valid_o ? mem_q[sel][rd_q[sel][AW-1:0]] : '0;

  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      wr_d[v] = wr_q[v] + OCW'(store[v]);
      rd_d[v] = rd_q[v] + OCW'(rd_en && sel == VC_W'(v));
    end
    rr_d   = rr_q;
    hold_d = hold_q;
    hvc_d  = hvc_q;
    if (rd_en) begin
      rr_d   = VC_W'((int'(sel) + 1) % N_VC);
      hold_d = 1'b0;
    end else if (valid_o) begin
      hold_d = 1'b1;
      hvc_d  = sel;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < N_VC; v++) begin
        wr_q[v] <= '0;
        rd_q[v] <= '0;
        st_q[v] <= IDLE;
      end
      err_q  <= '0;
      rr_q   <= '0;
      hvc_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        wr_q[v] <= wr_d[v];
        rd_q[v] <= rd_d[v];
        st_q[v] <= st_d[v];
      end
      err_q  <= err_d;
      rr_q   <= rr_d;
      hvc_q  <= hvc_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && legal[vc_id_i])
      mem_q[vc_id_i][wr_q[vc_id_i][AW-1:0]] <= fdata_i;
  end

endmodule
